// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control FSM for the multi-cycle RV32I core (lw, sw, R, I, beq, jal).
// Optional feature macro WAIT_TIMEOUT_EN: memory-wait timeout and illegal-opcode trap into ERR.
module multicycle_ctrl_fsm #(
`ifdef WAIT_TIMEOUT_EN
    parameter int unsigned WAIT_MAX = 15
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [3:0] state_o,
    output logic       err
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERR      = 4'd15
    } state_t;

    state_t state;
    logic   timeout;

`ifdef WAIT_TIMEOUT_EN
    localparam state_t ILLEGAL = ERR;
    logic [3:0] cnt;
    logic       waiting;
    assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign timeout = waiting && !mem_ready && (cnt == 4'(WAIT_MAX - 1));
    assign err     = (state == ERR);
    // wait counter: counts idle memory cycles, clears on any state change
    always_ff @(posedge clk) begin
        if (rst) cnt <= 4'd0;
        else     cnt <= (waiting && !mem_ready && !timeout) ? cnt + 4'd1 : 4'd0;
    end
`else
    localparam state_t ILLEGAL = FETCH;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign state_o = state;
    assign imm_src = (op == 7'd35) ? 2'b01 : (op == 7'd99) ? 2'b10 : (op == 7'd111) ? 2'b11 : 2'b00;

    // state sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    state <= mem_ready ? DECODE : (timeout ? ERR : FETCH);
                DECODE:   state <= (op == 7'd3 || op == 7'd35) ? MEMADR :
                                   (op == 7'd51)  ? EXECR :
                                   (op == 7'd19)  ? EXECI :
                                   (op == 7'd99)  ? BEQ   :
                                   (op == 7'd111) ? JAL   : ILLEGAL;
                MEMADR:   state <= (op == 7'd3) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= mem_ready ? MEMWB : (timeout ? ERR : MEMREAD);
                MEMWRITE: state <= mem_ready ? FETCH : (timeout ? ERR : MEMWRITE);
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                JAL:      state <= ALUWB;
                ERR:      state <= ILLEGAL;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore datapath decode; FETCH and BEQ strobes gated by mem_ready/zero, all strobes killed in reset
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized self-checking bench against a per-instruction state-sequence model.
module tb_multicycle_ctrl_fsm;
    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [3:0] state_o;
    logic       err;
    int         n_vec;
    int         n_err;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .state_o(state_o), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, err}
    logic [13:0] ctrl;
    assign ctrl = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, err};

    // control word the specification lists for each state
    function automatic logic [13:0] exp_ctrl(input int s, input bit mr, input bit z);
        case (s)
            0:  return {mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
            2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
            3:  return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
            5:  return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
            8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            9:  return {z,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
            10: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
            default: return {13'd0, 1'b1};
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            7'd35:   return 2'b01;
            7'd99:   return 2'b10;
            7'd111:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // one instruction from FETCH: wf fetch waits, wm data-memory waits; model is the state walk per opcode
    task automatic test_instr(input logic [6:0] o, input bit z, input int wf, input int wm);
        int qs[$];
        bit qm[$];
        repeat (wf) begin qs.push_back(0); qm.push_back(1'b0); end
        qs.push_back(0); qm.push_back(1'b1);
        qs.push_back(1); qm.push_back(1'($urandom_range(0, 1)));
        case (o)
            7'd3: begin
                qs.push_back(2); qm.push_back(1'($urandom_range(0, 1)));
                repeat (wm) begin qs.push_back(3); qm.push_back(1'b0); end
                qs.push_back(3); qm.push_back(1'b1);
                qs.push_back(4); qm.push_back(1'($urandom_range(0, 1)));
            end
            7'd35: begin
                qs.push_back(2); qm.push_back(1'($urandom_range(0, 1)));
                repeat (wm) begin qs.push_back(5); qm.push_back(1'b0); end
                qs.push_back(5); qm.push_back(1'b1);
            end
            7'd51: begin
                qs.push_back(6); qm.push_back(1'($urandom_range(0, 1)));
                qs.push_back(8); qm.push_back(1'($urandom_range(0, 1)));
            end
            7'd19: begin
                qs.push_back(7); qm.push_back(1'($urandom_range(0, 1)));
                qs.push_back(8); qm.push_back(1'($urandom_range(0, 1)));
            end
            7'd99: begin
                qs.push_back(9); qm.push_back(1'($urandom_range(0, 1)));
            end
            7'd111: begin
                qs.push_back(10); qm.push_back(1'($urandom_range(0, 1)));
                qs.push_back(8); qm.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        for (int i = 0; i < qs.size(); i++) begin
            op = o;
            zero = z;
            mem_ready = qm[i];
            #4;
            n_vec++;
            if (state_o !== 4'(qs[i])) begin
                n_err++;
                $display("FAIL state op=%0d step=%0d got=%0d want=%0d", o, i, state_o, qs[i]);
            end
            n_vec++;
            if (ctrl !== exp_ctrl(qs[i], qm[i], z)) begin
                n_err++;
                $display("FAIL ctrl op=%0d step=%0d state=%0d got=%h want=%h", o, i, qs[i], ctrl, exp_ctrl(qs[i], qm[i], z));
            end
            n_vec++;
            if (imm_src !== exp_imm(o)) begin
                n_err++;
                $display("FAIL imm_src op=%0d got=%b want=%b", o, imm_src, exp_imm(o));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        op = 7'd19;
        for (int i = 0; i < 2; i++) begin
            #4;
            n_vec++;
            if (state_o !== 4'd0 || {pc_write, ir_write, mem_write, reg_write} !== 4'b0) begin
                n_err++;
                $display("FAIL reset cyc=%0d state=%0d strobes=%b want state=0 strobes=0000", i, state_o, {pc_write, ir_write, mem_write, reg_write});
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #4;
        n_vec++;
        if (state_o !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release state=%0d ir_write=%b pc_write=%b want 0,1,1", state_o, ir_write, pc_write);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #4;
        n_vec++;
        if (state_o !== 4'd1 || {pc_write, ir_write, mem_write, reg_write} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_decode state=%0d strobes=%b want 1,0000", state_o, {pc_write, ir_write, mem_write, reg_write});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // reset arriving in MEMWRITE must suppress the write and restart at FETCH
    task automatic test_abort();
        op = 7'd35;
        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        mem_ready = 1'b0;
        #4;
        n_vec++;
        if (state_o !== 4'd5 || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL abort state=%0d mem_write=%b want 5,0", state_o, mem_write);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        n_vec++;
        if (state_o !== 4'd0 || ir_write !== 1'b0) begin
            n_err++;
            $display("FAIL abort_restart state=%0d ir_write=%b want 0,0", state_o, ir_write);
        end
        @(posedge clk); #1;
    endtask

`ifdef WAIT_TIMEOUT_EN
    task automatic test_timeout();
        mem_ready = 1'b0;
        op = 7'd19;
        for (int i = 0; i < 15; i++) begin
            #4;
            n_vec++;
            if (state_o !== 4'd0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_wait cyc=%0d state=%0d err=%b want 0,0", i, state_o, err);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_vec++;
            if (state_o !== 4'd15 || ctrl !== {13'd0, 1'b1}) begin
                n_err++;
                $display("FAIL timeout_err cyc=%0d state=%0d ctrl=%h want 15,0001", i, state_o, ctrl);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        n_vec++;
        if (state_o !== 4'd0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear state=%0d err=%b want 0,0", state_o, err);
        end
        op = 7'd0;
        @(posedge clk); #1;
        #4;
        n_vec++;
        if (state_o !== 4'd1) begin
            n_err++;
            $display("FAIL illegal_decode state=%0d want 1", state_o);
        end
        @(posedge clk); #1;
        #4;
        n_vec++;
        if (state_o !== 4'd15 || err !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_err state=%0d err=%b want 15,1", state_o, err);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [6:0] ops [7];
        ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd0};
        repeat (40) begin
`ifdef WAIT_TIMEOUT_EN
            test_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
`else
            test_instr(ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
`endif
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        op = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_instr(7'd3, 1'b0, 0, 0);
        test_instr(7'd35, 1'b0, 0, 3);
        test_instr(7'd99, 1'b1, 0, 0);
        test_instr(7'd99, 1'b0, 0, 0);
        test_instr(7'd111, 1'b0, 0, 0);
        test_instr(7'd51, 1'b1, 1, 0);
        test_instr(7'd19, 1'b0, 2, 0);
        test_instr(7'd19, 1'b0, 14, 0);
        test_instr(7'd3, 1'b1, 0, 14);
        test_instr(7'd35, 1'b0, 0, 14);
`ifndef WAIT_TIMEOUT_EN
        test_instr(7'd0, 1'b0, 0, 0);
        test_instr(7'd127, 1'b1, 1, 0);
`endif
        test_abort();
        test_random();
`ifdef WAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
